mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data ports onto one synchronous-read memory, 2 cycles grant to done.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise data wins every tie.
module mem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state;
    logic   win_d;
    logic   idle;
    logic   pick_d;

`ifdef MEM_ARB_RR_EN
    logic last_d;
    assign pick_d = ~last_d;
    always_ff @(posedge clk or negedge sys_rst)
        if (!sys_rst)
            last_d <= 1'b0;
        else if (f_gnt || d_gnt)
            last_d <= d_gnt;
`else
    assign pick_d = 1'b1;
`endif

    // Gating with sys_rst keeps grants low while reset is held.
    assign idle  = sys_rst && state == IDLE;
    assign d_gnt = idle && d_req && (!f_req || pick_d);
    assign f_gnt = idle && f_req && !d_gnt;
    assign rdata = state == RESP ? mem_rdata : '0;

    // mem_addr/mem_wdata double as the request latch and hold outside ISSUE.
    always_ff @(posedge clk or negedge sys_rst)
        if (!sys_rst) begin
            state     <= IDLE;
            win_d     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            f_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE:
                    if (f_gnt || d_gnt) begin
                        state    <= ISSUE;
                        win_d    <= d_gnt;
                        mem_en   <= 1'b1;
                        mem_we   <= d_gnt && d_we;
                        mem_addr <= d_gnt ? d_addr : f_addr;
                        if (d_gnt)
                            mem_wdata <= d_wdata;
                    end
                ISSUE: begin
                    state  <= RESP;
                    f_done <= !win_d;
                    d_done <= win_d;
                end
                default: state <= IDLE;
            endcase
        end
endmodule
